// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding
// and the pipeline-depth helper used by every instance.
package adder_pkg;

    // Operation select encoding on the op input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Pipeline depth: one stage per SEG-bit slice of the operand width.
    // A non-positive segment width yields 1 so the division stays defined;
    // the top level rejects that configuration at elaboration anyway.
    function automatic int calc_stages(input int width, input int seg);
        if (seg < 1) begin
            return 1;
        end
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit ripple-carry segment built from single-bit full adders. One
// segment is resolved per pipeline stage of pipelined_adder.

// Single-bit full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// Ripple chain of SEG full adders with carry in and carry out.
module adder_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [SEG:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// The WIDTH-bit carry chain is cut into SEG-bit segments; stage k resolves
// segment k using the carry registered by stage k-1. Operand slices not yet
// consumed and result slices already resolved ride along with their beat,
// and a final output register presents {carry_out, result} plus signed
// overflow. A single advance enable stalls the whole pipe under backpressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int STAGES   = calc_stages(WIDTH, SEG);
    localparam int LAST     = STAGES - 1;
    localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;

    // Reject widths that do not split into whole segments.
    if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
    end

    // A word viewed as STAGES slices of SEG bits; slice k belongs to stage k.
    typedef logic [STAGES-1:0][SEG-1:0] word_t;

    // Effective operands: subtract is A + ~B with carry-in 1.
    word_t a_eff;
    word_t b_eff;
    logic  cin_first;

    // Global advance enable shared by every pipeline register.
    logic en;

    // Per-stage pipeline registers.
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_carry;
    word_t             st_a   [STAGES];
    word_t             st_b   [STAGES];
    word_t             st_res [STAGES];

    // Segment adder inputs and outputs, one per stage.
    logic [STAGES-1:0][SEG-1:0] seg_a;
    logic [STAGES-1:0][SEG-1:0] seg_b;
    logic [STAGES-1:0][SEG-1:0] seg_sum;
    logic [STAGES-1:0]          seg_cin;
    logic [STAGES-1:0]          seg_cout;

    logic a_msb;
    logic b_msb;
    logic res_msb;

    assign a_eff     = a;
    assign b_eff     = (op == OP_SUB) ? ~b : b;
    assign cin_first = (op == OP_SUB);

    // The pipe may advance unless a finished result is waiting unconsumed.
    // Depends only on registered state and out_ready, never on in_valid.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Stage 0 works straight off the inputs at the accepting edge.
            assign seg_a[0]   = a_eff[0];
            assign seg_b[0]   = b_eff[0];
            assign seg_cin[0] = cin_first;
        end else begin : g_rest
            // Later stages take their slice from the skewed operand copy.
            assign seg_a[k]   = st_a[k-1][k];
            assign seg_b[k]   = st_b[k-1][k];
            assign seg_cin[k] = st_carry[k-1];
        end

        adder_segment #(
            .SEG (SEG)
        ) u_segment (
            .a    (seg_a[k]),
            .b    (seg_b[k]),
            .cin  (seg_cin[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k])
        );
    end

    // Overflow terms come from the operand MSBs carried down the pipe.
    assign a_msb   = st_a[LAST][STAGES-1][SEG-1];
    assign b_msb   = st_b[LAST][STAGES-1][SEG-1];
    assign res_msb = st_res[LAST][STAGES-1][SEG-1];

    // Advance every stage and the output register together when enabled.
    // NOTE: sequential state uses non-blocking assignments so each stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data and skew registers are cleared along with the valid
            // bits, so nothing from an aborted beat can surface after reset.
            st_valid  <= '0;
            st_carry  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_res[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            st_valid[0]  <= in_valid;
            st_carry[0]  <= seg_cout[0];
            st_a[0]      <= a_eff;
            st_b[0]      <= b_eff;
            st_res[0]    <= '0;
            st_res[0][0] <= seg_sum[0];

            for (int k = 1; k < STAGES; k++) begin
                st_valid[k]  <= st_valid[k-1];
                st_carry[k]  <= seg_cout[k];
                st_a[k]      <= st_a[k-1];
                st_b[k]      <= st_b[k-1];
                st_res[k]    <= st_res[k-1];
                st_res[k][k] <= seg_sum[k];
            end

            out_valid <= st_valid[LAST];
            sum       <= {st_carry[LAST], st_res[LAST]};
            ovf       <= (a_msb == b_msb) && (res_msb != a_msb);
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder at WIDTH=8, SEG=4 (two stages).
// Expected results come from an arithmetic reference model and a FIFO of
// accepted beats; a monitor checks every consumed result in order.
module tb_pipelined_adder;

    localparam int WIDTH = 8;
    localparam int SEG   = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit done    = 1'b0;

    // Expected {ovf, sum} per accepted beat, oldest first.
    logic [9:0] exp_q [$];
    // Cycle number at which each result was observed being consumed.
    int cons_log [$];

    pipelined_adder #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: 9-bit unsigned sum of A and B' plus carry-in, and signed
    // overflow from the true signed result leaving the 8-bit range.
    function automatic logic [9:0] ref_model(input logic [7:0] av, input logic [7:0] bv,
                                             input logic opv);
        logic [8:0] s;
        int         r;
        int         sa;
        int         sb;
        sa = $signed(av);
        sb = $signed(bv);
        if (!opv) begin
            s = {1'b0, av} + {1'b0, bv};
            r = sa + sb;
        end else begin
            s = {1'b0, av} + {1'b0, ~bv} + 9'd1;
            r = sa - sb;
        end
        return {(r > 127) || (r < -128), s};
    endfunction

    // Scoreboard: a result visible at the negedge with out_ready high is
    // consumed at the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("mon_sum", sum, e[8:0]);
                check("mon_ovf", ovf, e[9]);
                cons_log.push_back(cyc);
            end
        end
    end

    // Offer one beat and hold it until accepted; returns just after the
    // accepting edge with in_valid still asserted.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic opv);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op       = opv;
        for (int k = 0; k < 100 && !taken; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_model(av, bv, opv));
                taken = 1'b1;
            end
            @(posedge clk);
            #2;
        end
        if (!taken) check("send_timeout", 0, 1);
    endtask

    // Single beat into an idle pipe with latency and value checks.
    task automatic directed(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic opv, input logic [8:0] exp_sum, input logic exp_ovf);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op       = opv;
        @(negedge clk);
        check({tag, "_ready"}, in_ready, 1);
        exp_q.push_back(ref_model(av, bv, opv));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat0"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_lat2"}, out_valid, 1);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_ovf"}, ovf, exp_ovf);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d beats pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #2;

        // Directed corner cases.
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 9'h17F, 1'b1);
        directed("sub_05_07", 8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0);

        // Back-to-back random stream, one result per cycle.
        base = cons_log.size();
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_count", cons_log.size() - base, 20);
        if (cons_log.size() >= base + 20) begin
            check("stream_span", cons_log[base+19] - cons_log[base], 19);
        end
        @(posedge clk);
        #2;

        // Stall with two beats in flight.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        send(8'h90, 8'h20, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_sum", sum, exp_q[0][8:0]);
            check("stall_ovf", ovf, exp_q[0][9]);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_first", out_valid, 1);
        @(negedge clk);
        check("release_second", out_valid, 1);
        @(negedge clk);
        check("release_empty", out_valid, 0);
        @(posedge clk);
        #2;

        // Random stream under random backpressure; order must hold.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(8'($urandom), 8'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #2;
                    end
                end
                in_valid = 1'b0;
                done     = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("bp_drain", exp_q.size(), 0);
        @(posedge clk);
        #2;

        // Reset with two beats in flight.
        send(8'h11, 8'h22, 1'b0);
        send(8'h7F, 8'h7F, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #2;
        directed("post_rst_sub", 8'h3C, 8'h0F, 1'b1, 9'h12D, 1'b0);

        repeat (3) @(negedge clk);
        check("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake. It is the sequential successor to the combinational n-bit ripple adder. The WIDTH-bit carry chain is split into SEG-bit segments, and each segment is registered in its own pipeline stage, so clock frequency does not depend on WIDTH. It sits in the neuron datapath wherever wide additions must close timing, such as synaptic weight summation and membrane-potential updates.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage.
- STAGES (localparam), WIDTH/SEG, pipeline depth.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  1  0 = add (A+B), 1 = subtract (A−B).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH+1  {carry_out, result}; for subtract, the MSB is the carry of A+~B+1, so 1 means no borrow.
- ovf  out  1  signed overflow of the WIDTH-bit result.

## Operation
- Subtract is implemented as A + ~B with carry-in 1. There is no separate subtractor.
- Stage k (k = 0..STAGES−1) adds bits [k·SEG +: SEG] of A and B' with the carry registered from stage k−1. Stage 0 takes carry-in = op.
- Skew registers: the upper, not-yet-consumed operand slices travel forward with their beat. Lower, already-resolved result slices are carried forward so the full word aligns at the last stage.
- The carry-out of the top segment becomes sum[WIDTH].
- ovf = (A'[MSB] == B'[MSB]) && (result[MSB] != A'[MSB]), where A'/B' are the effective operands (B' is B inverted for subtract). The operand MSBs are carried to the last stage so this can be evaluated there.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Global advance enable: en = !out_valid || out_ready. It gates every pipeline register, including the per-stage valid bits.
  - in_ready = en, combinational. There is no combinational path from in_valid to in_ready.
- Bubbles: a stage valid bit loads in_valid or the upstream valid when en is high. Data registers may load unconditionally when en is high.
- Stall: when out_valid && !out_ready, every stage holds. sum, ovf and out_valid are stable until consumed.
- Reset: all valid bits, data and carry registers, sum and ovf clear to 0 asynchronously. In-flight beats are discarded and no partial result appears after reset is released.

## Timing
- Latency: a beat accepted at edge t presents out_valid=1 with its result after edge t+STAGES, provided there are no stalls.
- Throughput: one beat per cycle while out_ready=1.
- A stall of S cycles adds exactly S cycles to every in-flight beat. Beat order is preserved and nothing is dropped or duplicated.
- Simultaneous accept and consume in the same cycle is legal, and occupancy is unchanged.
- Output values after reset: out_valid=0, sum=0, ovf=0. in_ready=1 once rst is deasserted, because out_valid=0.
- Operands and op are sampled only on the accepting edge. Changing them while the block is not accepting has no effect.

## Structure
- Shared package adder_pkg holds the op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1.
- The package also holds the function computing STAGES.
- One sub-module, adder_segment (parameter SEG), implements an SEG-bit ripple of full_adder instances with cin/cout. Each stage instantiates one adder_segment.
- Stage registers, skew registers and valid/enable logic stay in pipelined_adder, built with a generate loop over STAGES.
- An elaboration-time check fails if WIDTH % SEG != 0 or SEG < 1.

## Test plan
All scenarios use WIDTH=8, SEG=4, so STAGES=2.
- Add 0xFF + 0x01: sum=0x100, ovf=0, out_valid rising exactly 2 cycles after accept.
- Add 0x7F + 0x01: sum=0x080, ovf=1. Subtract 0x80 − 0x01: sum=0x17F, ovf=1.
- Subtract 0x05 − 0x07: sum=0x0FE (MSB=0, borrow), ovf=0.
- Back-to-back stream of 20 random beats with out_ready=1: one result per cycle, in order, all matching the reference model.
- out_ready held low for 5 cycles with 2 beats in flight: in_ready=0, sum/ovf/out_valid stable. On release the two results emerge on consecutive cycles.
- Assert rst for 1 cycle while 2 beats are in flight: all outputs go to 0 immediately and no stale result appears. The next beat after reset has normal latency.
